// File: rtl/max_window_packer.sv
// max_window_packer: packs a sample stream into N_WORDS-wide windows with a fill buffer behind an output register
module max_window_packer #(
  parameter int WORD_W = 32,
  parameter int N_WORDS = 32,
  parameter logic [WORD_W-1:0] PAD_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*N_WORDS-1:0]   out_data,
  output logic [$clog2(N_WORDS):0]    out_count
);
  localparam int CW = $clog2(N_WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(N_WORDS - 1);
  logic [WORD_W*N_WORDS-1:0] fill_data, merged;
  logic [CW-1:0] fill_cnt;
  logic sealed, accept, close, xfer;
  assign in_ready = ~sealed;
  assign accept = in_valid & ~sealed;
  assign close = accept & (in_last | fill_cnt == LAST);
  assign xfer = (close | sealed) & (~out_valid | out_ready);
  // closing sample goes straight into the outgoing window, not via the fill buffer
  for (genvar k = 0; k < N_WORDS; k++) begin : g_slot
    assign merged[WORD_W*(N_WORDS-k)-1 -: WORD_W] = (accept && fill_cnt == CW'(k)) ?
      in_data : fill_data[WORD_W*(N_WORDS-k)-1 -: WORD_W];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_data <= {N_WORDS{PAD_VALUE}};
      fill_cnt <= '0;
      sealed <= 1'b0;
      out_valid <= 1'b0;
      out_data <= {N_WORDS{PAD_VALUE}};
      out_count <= '0;
    end else if (xfer) begin
      out_data <= merged;
      out_count <= fill_cnt + CW'(accept);
      out_valid <= 1'b1;
      fill_data <= {N_WORDS{PAD_VALUE}};
      fill_cnt <= '0;
      sealed <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        fill_data <= merged;
        fill_cnt <= fill_cnt + CW'(1);
      end
      sealed <= sealed | close;
    end
  end
endmodule

// File: tb/tb_max_window_packer.sv
// tb_max_window_packer: scoreboard-driven bench for max_window_packer
module tb_max_window_packer;
  localparam int W = 32;
  localparam int N = 32;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_last = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [W*N-1:0] out_data;
  logic [5:0] out_count;
  max_window_packer #(.WORD_W(W), .N_WORDS(N), .PAD_VALUE('0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count));
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  int cyc = 0, stalls = 0, n_hs = 0;
  logic [W*N-1:0] exp_q_data[$];
  int exp_q_cnt[$];
  int hs_cyc[$];
  logic [W*N-1:0] model_win = '0, last_data = '0, prev_data = '0;
  int model_cnt = 0, last_count = 0, prev_count = 0;
  bit prev_hold = 0;
  always @(posedge clk) cyc++;
  // scoreboard monitor: handshake completes on the following rising edge
  always @(negedge clk) begin
    if (rst_n && prev_hold) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== prev_data || out_count !== prev_count[5:0]) begin
        miscompares++;
        $display("FAIL hold_stable: valid=%b count=%0d required valid=1 count=%0d", out_valid, out_count, prev_count);
      end
    end
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      n_hs++;
      hs_cyc.push_back(cyc);
      last_data = out_data;
      last_count = int'(out_count);
      if (exp_q_data.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_window: count=%0d required no window", out_count);
      end else begin
        logic [W*N-1:0] ed;
        int ec;
        ed = exp_q_data.pop_front();
        ec = exp_q_cnt.pop_front();
        if (out_data !== ed || out_count !== ec[5:0]) begin
          miscompares++;
          $display("FAIL window: count=%0d data=%h required count=%0d data=%h", out_count, out_data, ec, ed);
        end
      end
    end
    prev_hold = rst_n && out_valid && !out_ready;
    prev_data = out_data;
    prev_count = int'(out_count);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [W-1:0] d, input bit last);
    int n = 0;
    in_valid = 1;
    in_data = d;
    in_last = last;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    stalls += n;
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    model_win[W*(N-model_cnt)-1 -: W] = d;
    model_cnt++;
    if (model_cnt == N || last) begin
      exp_q_data.push_back(model_win);
      exp_q_cnt.push_back(model_cnt);
      model_win = '0;
      model_cnt = 0;
    end
    step();
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (exp_q_data.size() != 0 && n < 200) begin
      step();
      n++;
    end
    step();
    step();
    vectors++;
    if (exp_q_data.size() != 0) begin
      miscompares++;
      $display("FAIL drain: pending=%0d required 0", exp_q_data.size());
    end
  endtask
  task automatic test_reset();
    rst_n = 0;
    #2;
    vectors++;
    if (out_valid !== 1'b0 || out_count !== 6'd0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_out: valid=%b count=%0d required valid=0 count=0 data=0", out_valid, out_count);
    end
    step();
    step();
    rst_n = 1;
    step();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask
  task automatic test_full_window();
    int h0 = n_hs;
    out_ready = 1;
    for (int i = 0; i < N; i++) send(W'(i), 0);
    drain();
    vectors++;
    if (n_hs - h0 != 1 || last_data[W*N-1 -: W] !== 0 || last_data[W-1:0] !== 31 || last_count != 32) begin
      miscompares++;
      $display("FAIL full_window: windows=%0d word0=%0d word31=%0d count=%0d required 1 0 31 32",
               n_hs - h0, last_data[W*N-1 -: W], last_data[W-1:0], last_count);
    end
  endtask
  task automatic test_short();
    int mx = -1;
    for (int i = 0; i < 5; i++) send(W'(i), i == 4);
    drain();
    for (int k = 0; k < N; k++) if (int'(last_data[W*(N-k)-1 -: W]) > mx) mx = int'(last_data[W*(N-k)-1 -: W]);
    vectors++;
    if (last_count != 5 || last_data[W*(N-5)-1:0] !== '0 || mx != 4) begin
      miscompares++;
      $display("FAIL short_window: count=%0d max=%0d required count=5 max=4 pad=0", last_count, mx);
    end
  endtask
  task automatic test_back_to_back();
    int h0 = n_hs, s0 = stalls, bad = 0;
    out_ready = 1;
    for (int i = 0; i < 3 * N; i++) send(W'(1000 + i), 0);
    drain();
    vectors++;
    if (n_hs - h0 != 3 || stalls != s0) begin
      miscompares++;
      $display("FAIL b2b_count: windows=%0d stalls=%0d required 3 0", n_hs - h0, stalls - s0);
    end
    for (int j = h0 + 1; j < n_hs; j++) if (hs_cyc[j] - hs_cyc[j-1] != N) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL b2b_gap: bad_gaps=%0d required 0", bad);
    end
  endtask
  task automatic test_backpressure();
    out_ready = 0;
    for (int i = 0; i < 2 * N; i++) send(W'(2000 + i), 0);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL sealed_ready: in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
    end
    repeat (6) step();
    vectors++;
    if (in_ready !== 1'b0 || out_count !== 6'd32 || out_data[W*N-1 -: W] !== 2000) begin
      miscompares++;
      $display("FAIL held_window1: in_ready=%b count=%0d word0=%0d required 0 32 2000",
               in_ready, out_count, out_data[W*N-1 -: W]);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data[W*N-1 -: W] !== 2032) begin
      miscompares++;
      $display("FAIL window2_present: valid=%b in_ready=%b word0=%0d required 1 1 2032",
               out_valid, in_ready, out_data[W*N-1 -: W]);
    end
    drain();
  endtask
  task automatic test_last_on_full();
    int h0 = n_hs;
    for (int i = 0; i < N; i++) send(W'(3000 + i), i == N - 1);
    send(W'(100), 1);
    drain();
    vectors++;
    if (n_hs - h0 != 2 || last_count != 1 || last_data[W*N-1 -: W] !== 100) begin
      miscompares++;
      $display("FAIL last_on_full: windows=%0d count=%0d word0=%0d required 2 1 100",
               n_hs - h0, last_count, last_data[W*N-1 -: W]);
    end
  endtask
  task automatic test_reset_mid();
    int h0;
    out_ready = 0;
    for (int i = 0; i < N + 17; i++) send(W'(4000 + i), 0);
    rst_n = 0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_count !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b count=%0d required 0 0", out_valid, out_count);
    end
    exp_q_data.delete();
    exp_q_cnt.delete();
    model_win = '0;
    model_cnt = 0;
    step();
    step();
    rst_n = 1;
    step();
    h0 = n_hs;
    out_ready = 1;
    for (int i = 0; i < N; i++) send(W'(5000 + i), 0);
    drain();
    vectors++;
    if (n_hs - h0 != 1 || last_count != 32 || last_data[W*N-1 -: W] !== 5000) begin
      miscompares++;
      $display("FAIL post_reset_window: windows=%0d count=%0d word0=%0d required 1 32 5000",
               n_hs - h0, last_count, last_data[W*N-1 -: W]);
    end
  endtask
  initial begin
    test_reset();
    test_full_window();
    test_short();
    test_back_to_back();
    test_backpressure();
    test_last_on_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
